// File: rtl/uart_rx_sink.sv
// uart_rx_sink: 8N1 UART receiver with mid-bit sampling, a one-entry
// valid/ready holding register, framing-error and overrun pulses.
module uart_rx_sink #(
  parameter int unsigned CLKS_PER_BIT = 234,
  parameter int unsigned CNT_W        = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       frame_err_o,
  output logic       overrun_o,
  output logic       busy_o
);

  localparam int unsigned HALF    = CLKS_PER_BIT / 2;
  localparam int unsigned IDX_W   = 4;
  localparam int unsigned BYTE_W  = 8;

  localparam logic [CNT_W-1:0] CNT_ZERO    = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_HALF_M1 = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_ZERO    = IDX_W'(0);
  localparam logic [IDX_W-1:0] IDX_ONE     = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(BYTE_W - 1);
  localparam logic [IDX_W-1:0] IDX_SAT     = IDX_W'(BYTE_W);

  // Elaboration-time parameter sanity checks
  generate
    if ((CLKS_PER_BIT < 4) || ((CLKS_PER_BIT % 2) != 0)) begin : g_bad_cpb
      $error("uart_rx_sink: CLKS_PER_BIT must be even and >= 4");
    end
    if ((CNT_W >= 32) || ((64'd1 << CNT_W) <= 64'(CLKS_PER_BIT))) begin : g_bad_cntw
      $error("uart_rx_sink: CNT_W too small for CLKS_PER_BIT");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_e;

  logic              sync1_q;
  logic              rx_s_q;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [BYTE_W-1:0] shift_q, shift_d;
  logic [BYTE_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              ferr_q, ferr_d;
  logic              ovr_q, ovr_d;
  logic              busy_q, busy_d;
  logic              byte_done;

  // Two-flop synchroniser for the asynchronous serial line (idle high)
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
    end else begin
      sync1_q <= rx_i;
      rx_s_q  <= sync1_q;
    end
  end

  // Receiver FSM, bit timing and holding-register next-state logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = valid_q;
    ferr_d    = 1'b0;
    ovr_d     = 1'b0;
    byte_done = 1'b0;

    // Consumer handshake frees the holding register; data is kept
    if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end

    unique case (state_q)
      S_IDLE: begin
        if (!rx_s_q) begin
          state_d = S_START;
          cnt_d   = CNT_ZERO;
        end
      end

      S_START: begin
        if (cnt_q == CNT_HALF_M1) begin
          cnt_d = CNT_ZERO;
          if (!rx_s_q) begin
            state_d = S_DATA;
            idx_d   = IDX_ZERO;
          end else begin
            // Start bit not low at its centre: treat as a glitch
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      S_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = CNT_ZERO;
          shift_d[idx_q[2:0]] = rx_s_q;
          if (idx_q != IDX_SAT) begin
            idx_d = idx_q + IDX_ONE;
          end
          if (idx_q == IDX_LAST) begin
            state_d = S_STOP;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      S_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = CNT_ZERO;
          if (rx_s_q) begin
            byte_done = 1'b1;
            state_d   = S_IDLE;
          end else begin
            // Stop bit low: report once, then wait out the break
            ferr_d  = 1'b1;
            state_d = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      S_BREAK: begin
        cnt_d = CNT_ZERO;
        if (rx_s_q) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = CNT_ZERO;
        idx_d   = IDX_ZERO;
      end
    endcase

    // Deliver a completed byte, or drop it when the register stays full
    if (byte_done) begin
      if (!valid_q || ready_i) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= CNT_ZERO;
      idx_q   <= IDX_ZERO;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
      busy_q  <= busy_d;
    end
  end

  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign frame_err_o = ferr_q;
  assign overrun_o   = ovr_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_uart_rx_sink.sv
// Self-checking bench for uart_rx_sink with CLKS_PER_BIT=8.
module tb_uart_rx_sink;

  localparam int unsigned C = 8;

  logic       clock;
  logic       reset;
  logic       rx_i;
  logic [7:0] data_o;
  logic       valid_o;
  logic       ready_i;
  logic       frame_err_o;
  logic       overrun_o;
  logic       busy_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Monitor statistics, cleared by each test
  int n_beats = 0;
  int n_ferr = 0;
  int n_ovr = 0;
  int valid_cycles = 0;
  int valid_rise_cyc = -1;
  logic valid_prev = 1'b0;

  logic [7:0] exp_q[$];

  uart_rx_sink #(.CLKS_PER_BIT(C), .CNT_W(8)) dut (
    .clock       (clock),
    .reset       (reset),
    .rx_i        (rx_i),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .frame_err_o (frame_err_o),
    .overrun_o   (overrun_o),
    .busy_o      (busy_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Scoreboard: every accepted beat must match the oldest expected byte
  always @(negedge clock) begin
    if (!reset) begin
      if (valid_o) valid_cycles++;
      if (valid_o && !valid_prev) valid_rise_cyc = cyc;
      if (frame_err_o) n_ferr++;
      if (overrun_o) n_ovr++;
      if (valid_o && ready_i) begin
        checks++;
        n_beats++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL beat_unexpected: got data_o=%02h, expected no beat", data_o);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (data_o !== e) begin
            errors++;
            $display("FAIL beat_data: got %02h, expected %02h", data_o, e);
          end
        end
      end
    end
    valid_prev = valid_o;
  end

  task automatic clear_stats();
    n_beats = 0;
    n_ferr = 0;
    n_ovr = 0;
    valid_cycles = 0;
    valid_rise_cyc = -1;
  endtask

  // Drives one 8N1 frame; called and returns at #1 after a rising edge
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rx_i = 1'b0;
    repeat (C) @(posedge clock);
    for (int i = 0; i < 8; i++) begin
      #1 rx_i = b[i];
      repeat (C) @(posedge clock);
    end
    #1 rx_i = stop_bit;
    repeat (C) @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rx_i = 1'b1;
    ready_i = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checks++;
    if ({data_o, valid_o, frame_err_o, overrun_o, busy_o} !== 12'h000) begin
      errors++;
      $display("FAIL reset_values: got %03h, expected 000",
               {data_o, valid_o, frame_err_o, overrun_o, busy_o});
    end
    @(posedge clock);
    #1 reset = 1'b0;
    repeat (4) @(posedge clock);
    #1;
  endtask

  task automatic test_single();
    int t0;
    int busy_mid;
    clear_stats();
    ready_i = 1'b1;
    t0 = cyc;
    exp_q.push_back(8'hA5);
    busy_mid = 0;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        repeat (40) @(negedge clock);
        busy_mid = int'(busy_o);
      end
    join
    repeat (4) @(posedge clock);
    #1;
    checks++;
    if (busy_mid !== 1) begin
      errors++;
      $display("FAIL single_busy_mid: got %0d, expected 1", busy_mid);
    end
    checks++;
    if (valid_rise_cyc !== t0 + 79) begin
      errors++;
      $display("FAIL single_latency: valid rose at cycle %0d, expected %0d", valid_rise_cyc, t0 + 79);
    end
    checks++;
    if (valid_cycles !== 1 || n_beats !== 1) begin
      errors++;
      $display("FAIL single_beat: valid_cycles=%0d beats=%0d, expected 1 and 1", valid_cycles, n_beats);
    end
    checks++;
    if (n_ferr !== 0 || n_ovr !== 0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL single_flags: ferr=%0d ovr=%0d busy=%b, expected 0 0 0", n_ferr, n_ovr, busy_o);
    end
  endtask

  task automatic test_overrun();
    clear_stats();
    ready_i = 1'b0;
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b1);
    send_frame(8'h3C, 1'b1);
    repeat (4) @(posedge clock);
    #1;
    checks++;
    if (n_ovr !== 1) begin
      errors++;
      $display("FAIL overrun_pulse: got %0d pulse cycles, expected 1", n_ovr);
    end
    checks++;
    if (valid_o !== 1'b1 || data_o !== 8'h55 || n_beats !== 0) begin
      errors++;
      $display("FAIL overrun_hold: valid=%b data=%02h beats=%0d, expected 1 55 0", valid_o, data_o, n_beats);
    end
    ready_i = 1'b1;
    @(posedge clock);
    #1;
    checks++;
    if (valid_o !== 1'b0 || data_o !== 8'h55 || n_beats !== 1) begin
      errors++;
      $display("FAIL overrun_drain: valid=%b data=%02h beats=%0d, expected 0 55 1", valid_o, data_o, n_beats);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] seq [3];
    seq[0] = 8'h01;
    seq[1] = 8'hFF;
    seq[2] = 8'h80;
    clear_stats();
    ready_i = 1'b1;
    for (int i = 0; i < 3; i++) exp_q.push_back(seq[i]);
    for (int i = 0; i < 3; i++) send_frame(seq[i], 1'b1);
    repeat (4) @(posedge clock);
    #1;
    checks++;
    if (n_beats !== 3 || valid_cycles !== 3 || n_ovr !== 0 || exp_q.size() !== 0) begin
      errors++;
      $display("FAIL b2b: beats=%0d valid_cycles=%0d ovr=%0d left=%0d, expected 3 3 0 0",
               n_beats, valid_cycles, n_ovr, exp_q.size());
    end
  endtask

  task automatic test_frame_error();
    clear_stats();
    ready_i = 1'b1;
    send_frame(8'hC3, 1'b0);
    repeat (40) @(posedge clock);
    #1;
    checks++;
    if (busy_o !== 1'b1 || n_ferr !== 1 || n_beats !== 0) begin
      errors++;
      $display("FAIL ferr_break: busy=%b ferr=%0d beats=%0d, expected 1 1 0", busy_o, n_ferr, n_beats);
    end
    rx_i = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if (busy_o !== 1'b1) begin
      errors++;
      $display("FAIL ferr_busy_hold: got %b, expected 1", busy_o);
    end
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL ferr_busy_release: got %b, expected 0", busy_o);
    end
    exp_q.push_back(8'h7E);
    send_frame(8'h7E, 1'b1);
    repeat (4) @(posedge clock);
    #1;
    checks++;
    if (n_beats !== 1 || n_ferr !== 1 || exp_q.size() !== 0) begin
      errors++;
      $display("FAIL ferr_recover: beats=%0d ferr=%0d left=%0d, expected 1 1 0", n_beats, n_ferr, exp_q.size());
    end
  endtask

  task automatic test_glitch();
    int busy_cnt;
    clear_stats();
    busy_cnt = 0;
    rx_i = 1'b0;
    repeat (2) @(posedge clock);
    #1 rx_i = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (busy_o) busy_cnt++;
    end
    checks++;
    if (busy_cnt !== 4) begin
      errors++;
      $display("FAIL glitch_busy: busy for %0d cycles, expected 4", busy_cnt);
    end
    checks++;
    if (n_beats !== 0 || valid_cycles !== 0 || n_ferr !== 0 || n_ovr !== 0) begin
      errors++;
      $display("FAIL glitch_quiet: beats=%0d valid=%0d ferr=%0d ovr=%0d, expected all 0",
               n_beats, valid_cycles, n_ferr, n_ovr);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset_midframe();
    logic [7:0] b;
    clear_stats();
    ready_i = 1'b0;
    send_frame(8'h11, 1'b1);
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if (valid_o !== 1'b1 || data_o !== 8'h11) begin
      errors++;
      $display("FAIL rst_pending: valid=%b data=%02h, expected 1 11", valid_o, data_o);
    end
    b = 8'h99;
    rx_i = 1'b0;
    repeat (C) @(posedge clock);
    for (int i = 0; i < 4; i++) begin
      #1 rx_i = b[i];
      repeat (C) @(posedge clock);
    end
    #1 rx_i = b[4];
    repeat (C / 2) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    rx_i = 1'b1;
    @(negedge clock);
    checks++;
    if ({data_o, valid_o, frame_err_o, overrun_o, busy_o} !== 12'h000) begin
      errors++;
      $display("FAIL rst_midframe: got %03h, expected 000",
               {data_o, valid_o, frame_err_o, overrun_o, busy_o});
    end
    repeat (3 * C) @(posedge clock);
    #1;
    clear_stats();
    ready_i = 1'b1;
    exp_q.push_back(8'h42);
    send_frame(8'h42, 1'b1);
    repeat (4) @(posedge clock);
    #1;
    checks++;
    if (n_beats !== 1 || exp_q.size() !== 0 || data_o !== 8'h42 || n_ferr !== 0 || n_ovr !== 0) begin
      errors++;
      $display("FAIL rst_recover: beats=%0d left=%0d data=%02h ferr=%0d ovr=%0d, expected 1 0 42 0 0",
               n_beats, exp_q.size(), data_o, n_ferr, n_ovr);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_overrun();
    test_back_to_back();
    test_frame_error();
    test_glitch();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
